// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with async reads, optional write->read
// bypass, optional hardwired-zero register 0 and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]     wr_data,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic                             sb_set_en,
  input  logic [ADDR_WIDTH-1:0]            sb_set_addr,
  output logic [ADDR_WIDTH:0]              busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [NUM_WR-1:0]     wr_ok;
  logic                  sb_ok;

  // With a hardwired zero register, anything aimed at r0 is discarded up front
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wr_en[j] &&
                 !(ZERO_REG != 0 && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0);
    end
    sb_ok = sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0);
  end

  // Retiring writes clear first so a same-cycle issue to that register wins
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) begin
        busy_d[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (sb_ok) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          mem_q[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  rbsy;

    assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Later write ports override earlier ones, matching the storage priority
    always_comb begin
      rdat = mem_q[ra];
      rbsy = busy_q[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
            rdat = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            rbsy = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0 && ra == '0) || !rst_n) begin
        rdat = '0;
        rbsy = 1'b0;
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdat;
    assign rd_busy[i] = rbsy;
  end

endmodule
